// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencer: condition codes,
// sequencer states and the absolute branch-target table.
package branch_pkg;

    localparam int BR_DATA_W = 8;
    localparam int BR_PC_W   = 10;
    localparam int BR_LUT_AW = 4;

    typedef enum logic [1:0] {
        BR_EQ     = 2'd0,
        BR_NE     = 2'd1,
        BR_LT     = 2'd2,
        BR_ALWAYS = 2'd3
    } brcond_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_OPB   = 3'd2,
        S_OPA   = 3'd3,
        S_REDIR = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    localparam logic [BR_PC_W-1:0] BR_TARGETS [2**BR_LUT_AW] = '{
        10'h000, 10'h008, 10'h040, 10'h080,
        10'h100, 10'h010, 10'h200, 10'h3FF,
        10'h020, 10'h0C0, 10'h180, 10'h2A0,
        10'h300, 10'h155, 10'h0AA, 10'h3C0
    };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: table index to absolute PC.
module branch_lut
    import branch_pkg::*;
#(
    parameter int LUT_AW = BR_LUT_AW,
    parameter int PC_W   = BR_PC_W
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   target
);

    assign target = PC_W'(BR_TARGETS[idx]);

endmodule

// File: rtl/branch_sequencer.sv
// Program counter and branch sequencer: fetches operands over two cycles on
// the shared compare bus, resolves the condition and redirects the PC.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W,
    parameter int PC_W   = BR_PC_W,
    parameter int LUT_AW = BR_LUT_AW
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Halt,
    input  logic              BranchReq,
    input  logic [1:0]        BrCond,
    input  logic [LUT_AW-1:0] TargetIdx,
    input  logic [DATA_W-1:0] BrMux,
    output logic              Branch,
    output logic [PC_W-1:0]   PC,
    output logic              Stall,
    output logic              Taken,
    output logic              Done
);

    seq_state_e        state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [DATA_W-1:0] opb_reg, opb_next;
    brcond_e           cond_reg, cond_next;
    logic [LUT_AW-1:0] idx_reg, idx_next;
    logic              taken_reg, taken_next;
    logic              cmp_result;
    logic [PC_W-1:0]   lut_target;

    branch_lut #(
        .LUT_AW (LUT_AW),
        .PC_W   (PC_W)
    ) u_lut (
        .idx    (idx_reg),
        .target (lut_target)
    );

    // In OPA the bus carries ReadR1 (operand A); operand B was latched in OPB.
    always_comb begin
        cmp_result = 1'b0;
        unique case (cond_reg)
            BR_EQ:     cmp_result = (BrMux == opb_reg);
            BR_NE:     cmp_result = (BrMux != opb_reg);
            BR_LT:     cmp_result = (BrMux < opb_reg);
            BR_ALWAYS: cmp_result = 1'b1;
            default:   cmp_result = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        opb_next   = opb_reg;
        cond_next  = cond_reg;
        idx_next   = idx_reg;
        taken_next = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_next = S_RUN;
                    pc_next    = '0;
                end
            end
            S_RUN: begin
                if (Halt) begin
                    state_next = S_DONE;
                end else if (BranchReq) begin
                    state_next = S_OPB;
                    cond_next  = brcond_e'(BrCond);
                    idx_next   = TargetIdx;
                end else begin
                    pc_next = pc_reg + PC_W'(1);
                end
            end
            S_OPB: begin
                opb_next   = BrMux;
                state_next = S_OPA;
            end
            S_OPA: begin
                taken_next = cmp_result;
                state_next = S_REDIR;
            end
            S_REDIR: begin
                pc_next    = taken_reg ? lut_target : pc_reg + PC_W'(1);
                state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            opb_reg   <= '0;
            cond_reg  <= BR_EQ;
            idx_reg   <= '0;
            taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            opb_reg   <= opb_next;
            cond_reg  <= cond_next;
            idx_reg   <= idx_next;
            taken_reg <= taken_next;
        end
    end

    // taken_reg is only ever set leaving OPA, so it is high exactly in REDIR.
    assign Taken  = taken_reg;
    assign PC     = pc_reg;
    assign Branch = (state_reg == S_OPA);
    assign Stall  = (state_reg == S_OPB) || (state_reg == S_OPA);
    assign Done   = (state_reg == S_DONE);

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: register file model drives the
// compare bus from the Branch select; each check is an immediate assertion.
module tb_branch_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n, Start, Halt, BranchReq;
    logic [1:0] BrCond;
    logic [3:0] TargetIdx;
    logic [7:0] BrMux;
    logic       Branch, Stall, Taken, Done;
    logic [9:0] PC;

    logic [7:0] r1, r2;
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign BrMux = Branch ? r1 : r2;

    branch_sequencer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Halt      (Halt),
        .BranchReq (BranchReq),
        .BrCond    (BrCond),
        .TargetIdx (TargetIdx),
        .BrMux     (BrMux),
        .Branch    (Branch),
        .PC        (PC),
        .Stall     (Stall),
        .Taken     (Taken),
        .Done      (Done)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one branch from RUN and walks OPB, OPA, REDIR back into RUN.
    task automatic do_branch(input string tag, input logic [1:0] cond, input logic [3:0] idx,
                             input logic [7:0] a, input logic [7:0] b, input logic exp_taken);
        r1 = a;
        r2 = b;
        BrCond = cond;
        TargetIdx = idx;
        BranchReq = 1'b1;
        tick();
        BranchReq = 1'b0;
        check({tag, " opb stall"}, 32'(Stall), 32'd1);
        check({tag, " opb branch"}, 32'(Branch), 32'd0);
        tick();
        check({tag, " opa branch"}, 32'(Branch), 32'd1);
        check({tag, " opa stall"}, 32'(Stall), 32'd1);
        tick();
        check({tag, " redir taken"}, 32'(Taken), 32'(exp_taken));
        check({tag, " redir stall"}, 32'(Stall), 32'd0);
        tick();
        check({tag, " taken cleared"}, 32'(Taken), 32'd0);
        $display("branch %s cond=%0d idx=%0d A=%02h B=%02h taken=%0b pc=%03h",
                 tag, cond, idx, a, b, exp_taken, PC);
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Halt = 1'b0; BranchReq = 1'b0;
        BrCond = 2'd0; TargetIdx = 4'd0; r1 = 8'h00; r2 = 8'h00;
        tick();
        tick();
        check("reset pc", 32'(PC), 32'h0);
        check("reset branch", 32'(Branch), 32'd0);
        check("reset stall", 32'(Stall), 32'd0);
        check("reset taken", 32'(Taken), 32'd0);
        check("reset done", 32'(Done), 32'd0);

        // 1: start and sequential fetch
        Reset_n = 1'b1;
        tick();
        check("idle holds pc", 32'(PC), 32'h0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("start pc", 32'(PC), 32'h0);
        repeat (5) tick();
        check("run pc5", 32'(PC), 32'h5);
        check("run stall", 32'(Stall), 32'd0);
        check("run branch", 32'(Branch), 32'd0);
        check("run done", 32'(Done), 32'd0);
        $display("run pc=%03h", PC);

        // 2: EQ taken
        do_branch("eq", 2'd0, 4'd2, 8'h3C, 8'h3C, 1'b1);
        check("eq pc", 32'(PC), 32'h040);

        // 3: unsigned LT both ways
        do_branch("lt_nt", 2'd2, 4'd3, 8'hFF, 8'h01, 1'b0);
        check("lt_nt pc", 32'(PC), 32'h041);
        do_branch("lt_t", 2'd2, 4'd3, 8'h01, 8'hFF, 1'b1);
        check("lt_t pc", 32'(PC), 32'h080);

        // 4: PC wrap, sequential and after not-taken redirect
        do_branch("always", 2'd3, 4'd7, 8'h00, 8'h00, 1'b1);
        check("always pc", 32'(PC), 32'h3FF);
        tick();
        check("wrap pc", 32'(PC), 32'h0);
        do_branch("always2", 2'd3, 4'd7, 8'h12, 8'h34, 1'b1);
        do_branch("ne_nt", 2'd1, 4'd5, 8'h5A, 8'h5A, 1'b0);
        check("ne_nt wrap pc", 32'(PC), 32'h0);
        do_branch("always3", 2'd3, 4'd7, 8'h00, 8'h00, 1'b1);
        do_branch("ne_t", 2'd1, 4'd5, 8'h01, 8'h02, 1'b1);
        check("ne_t pc", 32'(PC), 32'h010);

        // 5: Halt beats BranchReq; DONE holds; restart
        Halt = 1'b1; BranchReq = 1'b1;
        tick();
        Halt = 1'b0; BranchReq = 1'b0;
        check("halt done", 32'(Done), 32'd1);
        check("halt stall", 32'(Stall), 32'd0);
        check("halt pc", 32'(PC), 32'h010);
        tick();
        check("done holds pc", 32'(PC), 32'h010);
        check("done holds", 32'(Done), 32'd1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("restart pc", 32'(PC), 32'h0);
        check("restart done", 32'(Done), 32'd0);
        $display("halt/restart pc=%03h", PC);

        // Start ignored in RUN
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("start ignored in run", 32'(PC), 32'h2);

        // 6: reset mid-branch, then Start+BranchReq in IDLE
        r1 = 8'h11; r2 = 8'h22; BrCond = 2'd3; TargetIdx = 4'd6;
        BranchReq = 1'b1;
        tick();
        BranchReq = 1'b0;
        tick();
        check("pre-reset opa", 32'(Branch), 32'd1);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check("midreset branch", 32'(Branch), 32'd0);
        check("midreset stall", 32'(Stall), 32'd0);
        check("midreset pc", 32'(PC), 32'h0);
        tick();
        check("midreset no taken", 32'(Taken), 32'd0);
        check("midreset idle pc", 32'(PC), 32'h0);
        Start = 1'b1; BranchReq = 1'b1;
        tick();
        Start = 1'b0; BranchReq = 1'b0;
        check("idle breq ignored stall", 32'(Stall), 32'd0);
        check("idle start pc", 32'(PC), 32'h0);
        tick();
        check("idle start run", 32'(PC), 32'h1);
        $display("reset/idle pc=%03h", PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
